// File: rtl/axi4_pkg.sv
// Shared AXI4 constants and the LSU master state type.
// Also hosts the alignment rule used at request acceptance.
package axi4_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;

  typedef enum logic [2:0] {
    StIdle,
    StWreq,
    StWresp,
    StRreq,
    StRdata,
    StResp
  } lsu_state_e;

  // Sizes above a word can never be issued on a 32-bit bus.
  function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [2:0] size);
    logic mis;
    case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = addr_lo[0];
      SIZE_W:  mis = |addr_lo;
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/axi4_lane_align.sv
// Byte-lane steering for a 32-bit AXI data bus: store shift and strobes,
// load shift and zero-extending size mask.
module axi4_lane_align
  import axi4_pkg::*;
(
  input  logic [1:0]  i_st_off,
  input  logic [2:0]  i_st_size,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_st_data,
  output logic [3:0]  o_st_strb,
  input  logic [1:0]  i_ld_off,
  input  logic [2:0]  i_ld_size,
  input  logic [31:0] i_ld_data,
  output logic [31:0] o_ld_data
);

  logic [3:0]  w_st_base;
  logic [31:0] w_ld_shift;
  logic [31:0] w_ld_mask;

  always_comb begin
    case (i_st_size)
      SIZE_B:  w_st_base = 4'h1;
      SIZE_H:  w_st_base = 4'h3;
      default: w_st_base = 4'hF;
    endcase
  end

  always_comb begin
    case (i_ld_size)
      SIZE_B:  w_ld_mask = 32'h0000_00FF;
      SIZE_H:  w_ld_mask = 32'h0000_FFFF;
      default: w_ld_mask = 32'hFFFF_FFFF;
    endcase
  end

  assign o_st_data  = i_st_data << {i_st_off, 3'b000};
  assign o_st_strb  = w_st_base << i_st_off;
  assign w_ld_shift = i_ld_data >> {i_ld_off, 3'b000};
  assign o_ld_data  = w_ld_shift & w_ld_mask;

endmodule

// File: rtl/axi4_lsu_master.sv
// LSU-to-AXI4 initiator: one single-beat read or write outstanding at a time,
// returning right-aligned load data and an error flag to the LSU.
module axi4_lsu_master
  import axi4_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [3:0]  AXI_ID     = 4'd0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_wen,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [2:0]            i_req_size,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_resp_valid,
  input  logic                  i_resp_ready,
  output logic [DATA_WIDTH-1:0] o_resp_rdata,
  output logic                  o_resp_err,
  output logic                  o_m_awvalid,
  input  logic                  i_m_awready,
  output logic [ADDR_WIDTH-1:0] o_m_awaddr,
  output logic [3:0]            o_m_awid,
  output logic [7:0]            o_m_awlen,
  output logic [2:0]            o_m_awsize,
  output logic [1:0]            o_m_awburst,
  output logic                  o_m_wvalid,
  input  logic                  i_m_wready,
  output logic [DATA_WIDTH-1:0] o_m_wdata,
  output logic [3:0]            o_m_wstrb,
  output logic                  o_m_wlast,
  input  logic                  i_m_bvalid,
  output logic                  o_m_bready,
  input  logic [1:0]            i_m_bresp,
  input  logic [3:0]            i_m_bid,
  output logic                  o_m_arvalid,
  input  logic                  i_m_arready,
  output logic [ADDR_WIDTH-1:0] o_m_araddr,
  output logic [3:0]            o_m_arid,
  output logic [7:0]            o_m_arlen,
  output logic [2:0]            o_m_arsize,
  output logic [1:0]            o_m_arburst,
  input  logic                  i_m_rvalid,
  output logic                  o_m_rready,
  input  logic [DATA_WIDTH-1:0] i_m_rdata,
  input  logic [1:0]            i_m_rresp,
  input  logic                  i_m_rlast,
  input  logic [3:0]            i_m_rid
);

  lsu_state_e            r_state;
  logic                  r_awvalid, r_wvalid, r_arvalid, r_bready, r_rready;
  logic [ADDR_WIDTH-1:0] r_awaddr, r_araddr;
  logic [3:0]            r_awid, r_arid;
  logic [2:0]            r_awsize, r_arsize;
  logic [1:0]            r_awburst, r_arburst;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [3:0]            r_wstrb;
  logic                  r_wlast;
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic                  r_resp_err;

  logic [31:0] w_st_data;
  logic [3:0]  w_st_strb;
  logic [31:0] w_ld_data;
  logic        w_aw_hold, w_w_hold;

  // Store lanes come from the live request; load lanes from the issued AR.
  axi4_lane_align u_align (
    .i_st_off  (i_req_addr[1:0]),
    .i_st_size (i_req_size),
    .i_st_data (i_req_wdata),
    .o_st_data (w_st_data),
    .o_st_strb (w_st_strb),
    .i_ld_off  (r_araddr[1:0]),
    .i_ld_size (r_arsize),
    .i_ld_data (i_m_rdata),
    .o_ld_data (w_ld_data)
  );

  assign w_aw_hold = r_awvalid & ~i_m_awready;
  assign w_w_hold  = r_wvalid & ~i_m_wready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_bready     <= 1'b0;
      r_rready     <= 1'b0;
      r_awaddr     <= '0;
      r_araddr     <= '0;
      r_awid       <= '0;
      r_arid       <= '0;
      r_awsize     <= '0;
      r_arsize     <= '0;
      r_awburst    <= '0;
      r_arburst    <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_wlast      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_req_valid) begin
            if (is_misaligned(i_req_addr[1:0], i_req_size)) begin
              r_state      <= StResp;
              r_resp_valid <= 1'b1;
              r_resp_rdata <= '0;
              r_resp_err   <= 1'b1;
            end else if (i_req_wen) begin
              r_state   <= StWreq;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_awaddr  <= i_req_addr;
              r_awid    <= AXI_ID;
              r_awsize  <= i_req_size;
              r_awburst <= BURST_INCR;
              r_wdata   <= w_st_data;
              r_wstrb   <= w_st_strb;
              r_wlast   <= 1'b1;
            end else begin
              r_state   <= StRreq;
              r_arvalid <= 1'b1;
              r_araddr  <= i_req_addr;
              r_arid    <= AXI_ID;
              r_arsize  <= i_req_size;
              r_arburst <= BURST_INCR;
            end
          end
        end
        StWreq: begin
          // AW and W retire independently; move on once neither is pending.
          r_awvalid <= w_aw_hold;
          r_wvalid  <= w_w_hold;
          if (!w_aw_hold && !w_w_hold) begin
            r_state  <= StWresp;
            r_bready <= 1'b1;
          end
        end
        StWresp: begin
          if (r_bready && i_m_bvalid) begin
            r_state      <= StResp;
            r_bready     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= '0;
            r_resp_err   <= (i_m_bresp != RESP_OKAY) || (i_m_bid != AXI_ID);
          end
        end
        StRreq: begin
          if (i_m_arready) begin
            r_state   <= StRdata;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
          end
        end
        StRdata: begin
          if (r_rready && i_m_rvalid) begin
            r_state      <= StResp;
            r_rready     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_ld_data;
            r_resp_err   <= (i_m_rresp != RESP_OKAY) || !i_m_rlast || (i_m_rid != AXI_ID);
          end
        end
        StResp: begin
          if (i_resp_ready) begin
            r_state      <= StIdle;
            r_resp_valid <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Gated by reset so the LSU sees not-ready for the whole reset window.
  assign o_req_ready  = (r_state == StIdle) && !reset;

  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;
  assign o_m_awvalid  = r_awvalid;
  assign o_m_awaddr   = r_awaddr;
  assign o_m_awid     = r_awid;
  assign o_m_awlen    = 8'd0;
  assign o_m_awsize   = r_awsize;
  assign o_m_awburst  = r_awburst;
  assign o_m_wvalid   = r_wvalid;
  assign o_m_wdata    = r_wdata;
  assign o_m_wstrb    = r_wstrb;
  assign o_m_wlast    = r_wlast;
  assign o_m_bready   = r_bready;
  assign o_m_arvalid  = r_arvalid;
  assign o_m_araddr   = r_araddr;
  assign o_m_arid     = r_arid;
  assign o_m_arlen    = 8'd0;
  assign o_m_arsize   = r_arsize;
  assign o_m_arburst  = r_arburst;
  assign o_m_rready   = r_rready;

endmodule

// File: tb/tb_axi4_lsu_master.sv
// Directed bench for axi4_lsu_master: a delay-configurable AXI responder, a
// transaction-level expectation model and a per-cycle output checker.
module tb_axi4_lsu_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req_valid = 1'b0, i_req_wen = 1'b0;
  logic [31:0] i_req_addr = '0, i_req_wdata = '0;
  logic [2:0]  i_req_size = '0;
  logic        o_req_ready, o_resp_valid, o_resp_err;
  logic        i_resp_ready = 1'b0;
  logic [31:0] o_resp_rdata;
  logic        o_m_awvalid, o_m_wvalid, o_m_wlast, o_m_bready, o_m_arvalid, o_m_rready;
  logic        i_m_awready = 1'b0, i_m_wready = 1'b0, i_m_arready = 1'b0;
  logic        i_m_bvalid = 1'b0, i_m_rvalid = 1'b0, i_m_rlast = 1'b0;
  logic [31:0] o_m_awaddr, o_m_araddr, o_m_wdata;
  logic [3:0]  o_m_awid, o_m_arid, o_m_wstrb;
  logic [7:0]  o_m_awlen, o_m_arlen;
  logic [2:0]  o_m_awsize, o_m_arsize;
  logic [1:0]  o_m_awburst, o_m_arburst;
  logic [1:0]  i_m_bresp = '0, i_m_rresp = '0;
  logic [3:0]  i_m_bid = '0, i_m_rid = '0;
  logic [31:0] i_m_rdata = '0;

  axi4_lsu_master dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wen(i_req_wen),
    .i_req_addr(i_req_addr), .i_req_size(i_req_size), .i_req_wdata(i_req_wdata),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
    .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err),
    .o_m_awvalid(o_m_awvalid), .i_m_awready(i_m_awready), .o_m_awaddr(o_m_awaddr),
    .o_m_awid(o_m_awid), .o_m_awlen(o_m_awlen), .o_m_awsize(o_m_awsize),
    .o_m_awburst(o_m_awburst),
    .o_m_wvalid(o_m_wvalid), .i_m_wready(i_m_wready), .o_m_wdata(o_m_wdata),
    .o_m_wstrb(o_m_wstrb), .o_m_wlast(o_m_wlast),
    .i_m_bvalid(i_m_bvalid), .o_m_bready(o_m_bready), .i_m_bresp(i_m_bresp),
    .i_m_bid(i_m_bid),
    .o_m_arvalid(o_m_arvalid), .i_m_arready(i_m_arready), .o_m_araddr(o_m_araddr),
    .o_m_arid(o_m_arid), .o_m_arlen(o_m_arlen), .o_m_arsize(o_m_arsize),
    .o_m_arburst(o_m_arburst),
    .i_m_rvalid(i_m_rvalid), .o_m_rready(o_m_rready), .i_m_rdata(i_m_rdata),
    .i_m_rresp(i_m_rresp), .i_m_rlast(i_m_rlast), .i_m_rid(i_m_rid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit run_checks = 0;

  // Responder configuration.
  int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_ar_dly = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [3:0]  cfg_bid = 4'd0, cfg_rid = 4'd0;
  logic        cfg_rlast = 1'b1;
  logic [31:0] cfg_rdata = '0;
  int          aw_fires = 0, w_fires = 0, ar_fires = 0;
  logic [31:0] cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;

  // Expected transaction, as the LSU would describe it.
  bit          exp_busy = 0;
  logic        exp_wen, exp_mis, exp_err;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [2:0]  exp_size;
  logic [3:0]  exp_wstrb;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  initial begin : cycle_count
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin : responder
    int aw_cnt, w_cnt, ar_cnt;
    bit aw_got, w_got, ar_got, aw_nx, w_nx, ar_nx, b_nx, r_nx;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
    aw_got = 0; w_got = 0; ar_got = 0;
    aw_nx = 0; w_nx = 0; ar_nx = 0; b_nx = 0; r_nx = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        i_m_awready = 0; i_m_wready = 0; i_m_arready = 0; i_m_bvalid = 0; i_m_rvalid = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
        aw_nx = 0; w_nx = 0; ar_nx = 0; b_nx = 0; r_nx = 0;
        continue;
      end
      if (aw_nx) aw_got = 1;
      if (w_nx) w_got = 1;
      if (ar_nx) ar_got = 1;
      if (b_nx) begin i_m_bvalid = 0; aw_got = 0; w_got = 0; end
      if (r_nx) i_m_rvalid = 0;
      if (o_m_awvalid) begin i_m_awready = (aw_cnt >= cfg_aw_dly); aw_cnt++; end
      else begin i_m_awready = 0; aw_cnt = 0; end
      if (o_m_wvalid) begin i_m_wready = (w_cnt >= cfg_w_dly); w_cnt++; end
      else begin i_m_wready = 0; w_cnt = 0; end
      if (o_m_arvalid) begin i_m_arready = (ar_cnt >= cfg_ar_dly); ar_cnt++; end
      else begin i_m_arready = 0; ar_cnt = 0; end
      aw_nx = o_m_awvalid && i_m_awready;
      w_nx  = o_m_wvalid && i_m_wready;
      ar_nx = o_m_arvalid && i_m_arready;
      if (aw_nx) aw_fires++;
      if (ar_nx) ar_fires++;
      if (w_nx) begin w_fires++; cap_wdata = o_m_wdata; cap_wstrb = o_m_wstrb; end
      if (aw_got && w_got && !i_m_bvalid) begin
        i_m_bvalid = 1; i_m_bresp = cfg_bresp; i_m_bid = cfg_bid;
      end
      if (ar_got && !i_m_rvalid) begin
        i_m_rvalid = 1; i_m_rdata = cfg_rdata; i_m_rresp = cfg_rresp;
        i_m_rlast = cfg_rlast; i_m_rid = cfg_rid; ar_got = 0;
      end
      b_nx = i_m_bvalid && o_m_bready;
      r_nx = i_m_rvalid && o_m_rready;
    end
  end

  initial begin : compare
    forever begin
      @(posedge clk);
      #1;
      if (reset || !run_checks) continue;
      chk("req_ready", o_req_ready, !exp_busy);
      if (o_resp_valid) begin
        chk("resp_while_busy", exp_busy, 1);
        chk("resp_rdata", o_resp_rdata, exp_rdata);
        chk("resp_err", o_resp_err, exp_err);
      end
      if (o_m_awvalid) begin
        chk("aw_expected", exp_busy && exp_wen && !exp_mis, 1);
        chk("awaddr", o_m_awaddr, exp_addr);
        chk("awsize", o_m_awsize, exp_size);
        chk("awlen", o_m_awlen, 0);
        chk("awburst", o_m_awburst, 1);
        chk("awid", o_m_awid, 0);
      end
      if (o_m_wvalid) begin
        chk("w_expected", exp_busy && exp_wen && !exp_mis, 1);
        chk("wdata", o_m_wdata, exp_wdata);
        chk("wstrb", o_m_wstrb, exp_wstrb);
        chk("wlast", o_m_wlast, 1);
      end
      if (o_m_arvalid) begin
        chk("ar_expected", exp_busy && !exp_wen && !exp_mis, 1);
        chk("araddr", o_m_araddr, exp_addr);
        chk("arsize", o_m_arsize, exp_size);
        chk("arlen", o_m_arlen, 0);
        chk("arburst", o_m_arburst, 1);
        chk("arid", o_m_arid, 0);
      end
    end
  end

  // Model: what the bus and the LSU response must look like for one request.
  task automatic model_req(input logic wen, input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] wdata);
    int off, nbytes;
    logic [31:0] mask;
    off = int'(addr % 4);
    exp_wen = wen; exp_addr = addr; exp_size = size;
    exp_mis = (size > 3'd2) || ((addr % (32'd1 << size)) != 0);
    nbytes = (size > 3'd2) ? 4 : (1 << size);
    exp_wdata = wdata << (8 * off);
    exp_wstrb = 4'(((1 << nbytes) - 1) << off);
    mask = (nbytes == 1) ? 32'hFF : (nbytes == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
    if (exp_mis) begin
      exp_rdata = 0; exp_err = 1;
    end else if (wen) begin
      exp_rdata = 0; exp_err = (cfg_bresp != 0) || (cfg_bid != 0);
    end else begin
      exp_rdata = (cfg_rdata >> (8 * off)) & mask;
      exp_err = (cfg_rresp != 0) || !cfg_rlast || (cfg_rid != 0);
    end
  endtask

  task automatic drive_req(input logic wen, input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] wdata);
    model_req(wen, addr, size, wdata);
    exp_busy = 1;
    i_req_valid = 1; i_req_wen = wen; i_req_addr = addr; i_req_size = size;
    i_req_wdata = wdata;
    @(negedge clk);
    i_req_valid = 0;
  endtask

  task automatic txn(input string tag, input logic wen, input logic [31:0] addr,
                     input logic [2:0] size, input logic [31:0] wdata, input int hold,
                     input int exp_lat);
    int acc, aw0, w0, ar0;
    bit seen;
    @(negedge clk);
    chk({tag, "_idle"}, o_req_ready, 1);
    aw0 = aw_fires; w0 = w_fires; ar0 = ar_fires;
    drive_req(wen, addr, size, wdata);
    acc = cyc;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (o_resp_valid) begin seen = 1; break; end
      @(negedge clk);
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no resp_valid within 100 cycles", tag);
      exp_busy = 0;
      return;
    end
    chk({tag, "_latency"}, cyc - acc + 1, exp_lat);
    last_rdata = o_resp_rdata;
    last_err = o_resp_err;
    repeat (hold) @(negedge clk);
    i_resp_ready = 1;
    exp_busy = 0;
    @(negedge clk);
    i_resp_ready = 0;
    chk({tag, "_aw_fires"}, aw_fires - aw0, (wen && !exp_mis) ? 1 : 0);
    chk({tag, "_w_fires"}, w_fires - w0, (wen && !exp_mis) ? 1 : 0);
    chk({tag, "_ar_fires"}, ar_fires - ar0, (!wen && !exp_mis) ? 1 : 0);
  endtask

  initial begin : stimulus
    repeat (3) @(negedge clk);
    chk("rst_req_ready", o_req_ready, 0);
    chk("rst_valids", {o_m_awvalid, o_m_wvalid, o_m_arvalid, o_m_bready, o_m_rready}, 0);
    chk("rst_resp", {o_resp_valid, o_resp_err}, 0);
    chk("rst_rdata", o_resp_rdata, 0);
    chk("rst_awaddr", o_m_awaddr, 0);
    chk("rst_araddr", o_m_araddr, 0);
    chk("rst_wdata", o_m_wdata, 0);
    chk("rst_misc", {o_m_wstrb, o_m_wlast, o_m_awburst, o_m_arburst, o_m_awsize}, 0);
    #2 reset = 0;
    #1 chk("rst_release_ready", o_req_ready, 1);
    run_checks = 1;

    txn("st_word", 1, 32'h1000_0000, 3'd2, 32'hDEAD_BEEF, 0, 3);
    chk("st_word_wdata_lit", cap_wdata, 32'hDEAD_BEEF);
    chk("st_word_wstrb_lit", cap_wstrb, 4'hF);
    chk("st_word_err_lit", last_err, 0);

    cfg_aw_dly = 3;
    txn("st_byte", 1, 32'h8000_0003, 3'd0, 32'h0000_005A, 0, 6);
    chk("st_byte_wdata_lit", cap_wdata, 32'h5A00_0000);
    chk("st_byte_wstrb_lit", cap_wstrb, 4'h8);
    cfg_aw_dly = 0;

    cfg_rdata = 32'hABCD_1234;
    txn("ld_half", 0, 32'h8000_0002, 3'd1, 32'h0, 0, 3);
    chk("ld_half_rdata_lit", last_rdata, 32'h0000_ABCD);
    chk("ld_half_err_lit", last_err, 0);

    txn("ld_mis", 0, 32'h8000_0001, 3'd2, 32'h0, 0, 1);
    chk("ld_mis_err_lit", last_err, 1);
    chk("ld_mis_rdata_lit", last_rdata, 0);

    cfg_rresp = 2'b10;
    txn("ld_slverr", 0, 32'h8000_0004, 3'd2, 32'h0, 5, 3);
    chk("ld_slverr_err_lit", last_err, 1);
    cfg_rresp = 2'b00;

    cfg_rlast = 0;
    txn("ld_nolast", 0, 32'h8000_0008, 3'd2, 32'h0, 0, 3);
    cfg_rlast = 1;

    cfg_bresp = 2'b11;
    txn("st_decerr", 1, 32'h0000_0002, 3'd1, 32'h0000_1234, 2, 3);
    chk("st_half_wdata_lit", cap_wdata, 32'h1234_0000);
    chk("st_half_wstrb_lit", cap_wstrb, 4'hC);
    cfg_bresp = 2'b00;

    cfg_bid = 4'd5;
    txn("st_badid", 1, 32'h0000_0010, 3'd2, 32'h0102_0304, 0, 3);
    cfg_bid = 4'd0;

    cfg_rid = 4'd1;
    txn("ld_badid", 0, 32'h0000_0020, 3'd0, 32'h0, 0, 3);
    cfg_rid = 4'd0;

    cfg_rdata = 32'h1122_3344;
    txn("ld_byte", 0, 32'h0000_0031, 3'd0, 32'h0, 0, 3);
    chk("ld_byte_rdata_lit", last_rdata, 32'h0000_0033);

    txn("st_mis", 1, 32'h0000_0003, 3'd1, 32'hFFFF, 0, 1);
    txn("ld_size3", 0, 32'h0000_0000, 3'd3, 32'h0, 0, 1);

    cfg_w_dly = 2;
    txn("st_wdly", 1, 32'h0000_0040, 3'd2, 32'hCAFE_F00D, 0, 5);
    cfg_w_dly = 0;
    cfg_ar_dly = 2;
    txn("ld_ardly", 0, 32'h0000_0044, 3'd2, 32'h0, 1, 5);
    cfg_ar_dly = 0;

    // Abort a store stuck in the write-address phase.
    cfg_aw_dly = 20;
    @(negedge clk);
    drive_req(1, 32'h2000_0000, 3'd2, 32'h1234_5678);
    @(negedge clk);
    chk("abort_awvalid_before", o_m_awvalid, 1);
    #2 reset = 1;
    exp_busy = 0;
    @(negedge clk);
    chk("abort_valids", {o_m_awvalid, o_m_wvalid, o_m_arvalid, o_m_bready}, 0);
    chk("abort_awaddr", o_m_awaddr, 0);
    chk("abort_wdata", o_m_wdata, 0);
    chk("abort_resp_valid", o_resp_valid, 0);
    chk("abort_req_ready_in_rst", o_req_ready, 0);
    #2 reset = 0;
    #1 chk("abort_idle", o_req_ready, 1);
    cfg_aw_dly = 0;
    txn("st_after_abort", 1, 32'h2000_0004, 3'd2, 32'h8765_4321, 0, 3);
    chk("st_after_abort_wdata_lit", cap_wdata, 32'h8765_4321);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
